// File: rtl/event_counter_bank.sv
// N-channel rising-edge event counter. Each RTC tick snapshots the counters and streams the snapshot out serially.
// Define CNT_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
`timescale 1ns/1ps

module event_counter_bank_lane #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pad_in,
    input  logic          snap_en,
    output logic          pulse,
    output logic [CW-1:0] snap,
    output logic          ovf,
    output logic          snap_ovf
);
    logic [2:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d, snap_q, snap_d;
    logic          ovf_q, ovf_d, snap_ovf_q, snap_ovf_d;

    // Two synchroniser stages, plus a third stage that is used only for edge detection.
    assign pulse    = sync_q[1] & ~sync_q[2];
    assign snap     = snap_q;
    assign ovf      = ovf_q;
    assign snap_ovf = snap_ovf_q;

    always_comb begin
        sync_d     = {sync_q[1:0], pad_in};
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        if (snap_en) begin
            // An event in the snapshot cycle belongs to the new window.
            snap_d     = cnt_q;
            snap_ovf_d = ovf_q;
            cnt_d      = pulse ? CW'(1) : '0;
            ovf_d      = 1'b0;
        end else if (pulse) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
`ifdef CNT_SATURATE_EN
                cnt_d = cnt_q;
`else
                cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            snap_q     <= '0;
            snap_ovf_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            snap_q     <= snap_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end
endmodule

module event_counter_bank #(
    parameter  int NCH = 8,
    parameter  int CW  = 16,
    localparam int AW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] ch_in,
    input  logic           rtc_in,
    output logic           serial_out,
    output logic           sl_out,
    output logic [AW-1:0]  addr_out,
    output logic           ovf_ch_out,
    output logic           ovf_global,
    output logic           ovf_rtc_out,
    output logic           busy_out
);
    localparam int BW = $clog2(CW);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [NCH-1:0]         ch_pulse, ch_ovf, snap_ovf;
    logic [NCH-1:0][CW-1:0] snap;
    logic [2:0]             rtc_sync_q, rtc_sync_d;
    logic                   rtc_pulse, snap_en;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ch_q, ch_d, addr_q, addr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          serial_q, serial_d, sl_q, sl_d, ovf_ch_q, ovf_ch_d;
    logic          ovf_global_q, ovf_global_d, ovf_rtc_q, ovf_rtc_d, busy_q, busy_d;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        event_counter_bank_lane #(.CW(CW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_in  (ch_in[i]),
            .snap_en (snap_en),
            .pulse   (ch_pulse[i]),
            .snap    (snap[i]),
            .ovf     (ch_ovf[i]),
            .snap_ovf(snap_ovf[i])
        );
    end

    assign rtc_sync_d = {rtc_sync_q[1:0], rtc_in};
    assign rtc_pulse  = rtc_sync_q[1] & ~rtc_sync_q[2];
    assign snap_en    = rtc_pulse && (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        bit_d        = bit_q;
        ovf_rtc_d    = ovf_rtc_q;
        ovf_global_d = ovf_global_q;
        case (state_q)
            IDLE: if (rtc_pulse) begin
                state_d = LOAD;
                ch_d    = '0;
            end
            LOAD: begin
                state_d = SHIFT;
                bit_d   = BW'(CW - 1);
            end
            SHIFT: begin
                if (bit_q == '0) begin
                    if (ch_q == AW'(NCH - 1)) begin
                        state_d = IDLE;
                        ch_d    = '0;
                    end else begin
                        state_d = LOAD;
                        ch_d    = ch_q + 1'b1;
                    end
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (snap_en) begin
            ovf_rtc_d    = 1'b0;
            ovf_global_d = |ch_ovf;
        end else if (rtc_pulse) begin
            ovf_rtc_d = 1'b1;
        end

        // Outputs are decoded from the next state so that they are registered without extra latency.
        // The first LOAD follows the snapshot edge, so its overflow flag comes from the live counter.
        busy_d   = (state_d != IDLE);
        sl_d     = (state_d == LOAD);
        addr_d   = (state_d == IDLE) ? '0 : ch_d;
        ovf_ch_d = (state_d == IDLE) ? 1'b0 : (snap_en ? ch_ovf[ch_d] : snap_ovf[ch_d]);
        serial_d = (state_d == SHIFT) ? snap[ch_d][bit_d] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtc_sync_q   <= '0;
            state_q      <= IDLE;
            ch_q         <= '0;
            bit_q        <= '0;
            serial_q     <= 1'b0;
            sl_q         <= 1'b0;
            addr_q       <= '0;
            ovf_ch_q     <= 1'b0;
            ovf_global_q <= 1'b0;
            ovf_rtc_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rtc_sync_q   <= rtc_sync_d;
            state_q      <= state_d;
            ch_q         <= ch_d;
            bit_q        <= bit_d;
            serial_q     <= serial_d;
            sl_q         <= sl_d;
            addr_q       <= addr_d;
            ovf_ch_q     <= ovf_ch_d;
            ovf_global_q <= ovf_global_d;
            ovf_rtc_q    <= ovf_rtc_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_out  = serial_q;
    assign sl_out      = sl_q;
    assign addr_out    = addr_q;
    assign ovf_ch_out  = ovf_ch_q;
    assign ovf_global  = ovf_global_q;
    assign ovf_rtc_out = ovf_rtc_q;
    assign busy_out    = busy_q;
endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench for event_counter_bank: reset, counting, window boundary, overflow, busy RTC, level input.
`timescale 1ns/1ps

module tb_event_counter_bank;
    // A narrow counter keeps the wrap-around case to a few hundred events.
    localparam int NCH = 8;
    localparam int CW  = 8;
    localparam int AW  = $clog2(NCH);
    localparam int FRAMES = NCH * (CW + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] ch_in = '0;
    logic           rtc_in = 1'b0;
    logic           serial_out, sl_out, ovf_ch_out, ovf_global, ovf_rtc_out, busy_out;
    logic [AW-1:0]  addr_out;

    int n_chk = 0;
    int n_err = 0;
    logic [CW-1:0] rx_snap [NCH];
    logic          rx_ovf  [NCH];
    int            busy_len;

    event_counter_bank #(.NCH(NCH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_in      (ch_in),
        .rtc_in     (rtc_in),
        .serial_out (serial_out),
        .sl_out     (sl_out),
        .addr_out   (addr_out),
        .ovf_ch_out (ovf_ch_out),
        .ovf_global (ovf_global),
        .ovf_rtc_out(ovf_rtc_out),
        .busy_out   (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_ch(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            ch_in[ch] = 1'b1;
            @(negedge clk);
            ch_in[ch] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic tick();
        rtc_in = 1'b1;
        @(negedge clk);
        rtc_in = 1'b0;
    endtask

    task automatic readout(input int rtc_at);
        int waited;
        int cyc;
        int proto_err;
        waited    = 0;
        cyc       = 0;
        proto_err = 0;
        busy_len  = 0;
        while (!busy_out && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!busy_out) begin
            chk("busy_rise", busy_out, 1);
            return;
        end
        for (int k = 0; k < NCH; k++) begin
            rx_snap[k] = '0;
            for (int c = 0; c <= CW; c++) begin
                if (busy_out) busy_len++;
                if (addr_out !== AW'(k)) proto_err++;
                if (c == 0) begin
                    if (sl_out !== 1'b1 || serial_out !== 1'b0) proto_err++;
                    rx_ovf[k] = ovf_ch_out;
                end else begin
                    if (sl_out !== 1'b0) proto_err++;
                    if (ovf_ch_out !== rx_ovf[k]) proto_err++;
                    rx_snap[k] = {rx_snap[k][CW-2:0], serial_out};
                end
                if (cyc == rtc_at) rtc_in = 1'b1;
                else if (cyc == rtc_at + 1) rtc_in = 1'b0;
                cyc++;
                @(negedge clk);
            end
        end
        chk("frame_proto", proto_err, 0);
        chk("busy_len", busy_len, FRAMES);
        chk("busy_fall", busy_out, 0);
    endtask

    task automatic chk_others(input string tag, input int k);
        int nz;
        nz = 0;
        for (int j = 0; j < NCH; j++)
            if (j != k && (rx_snap[j] != '0 || rx_ovf[j] != 1'b0)) nz++;
        chk(tag, nz, 0);
    endtask

    initial begin
        int b;
        cycles(3);
        chk("rst_busy", busy_out, 0);
        chk("rst_sl", sl_out, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_serial", serial_out, 0);
        chk("rst_ovf_ch", ovf_ch_out, 0);
        chk("rst_ovf_glb", ovf_global, 0);
        chk("rst_ovf_rtc", ovf_rtc_out, 0);
        rst_n = 1'b1;
        cycles(3);

        // Basic count and readout.
        pulse_ch(2, 5);
        tick();
        readout(-10);
        chk("cnt_ch2", rx_snap[2], 5);
        chk_others("cnt_others", 2);
        chk("cnt_ovf_glb", ovf_global, 0);

        // An event coincident with the tick belongs to the next window.
        ch_in[0] = 1'b1;
        rtc_in   = 1'b1;
        @(negedge clk);
        ch_in[0] = 1'b0;
        rtc_in   = 1'b0;
        readout(-10);
        chk("bnd_win1", rx_snap[0], 0);
        tick();
        readout(-10);
        chk("bnd_win2", rx_snap[0], 1);
        chk_others("bnd_others", 0);

        // A level held high counts once.
        ch_in[4] = 1'b1;
        cycles(1000);
        ch_in[4] = 1'b0;
        cycles(3);
        tick();
        readout(-10);
        chk("level_ch4", rx_snap[4], 1);

        // Overflow: 2^CW + 1 events.
        pulse_ch(7, (1 << CW) + 1);
        tick();
        readout(-10);
`ifdef CNT_SATURATE_EN
        chk("ovf_snap7", rx_snap[7], (1 << CW) - 1);
`else
        chk("ovf_snap7", rx_snap[7], 1);
`endif
        chk("ovf_ch7", rx_ovf[7], 1);
        chk("ovf_glb", ovf_global, 1);
        chk_others("ovf_others", 7);
        tick();
        readout(-10);
        chk("ovf_clr_snap7", rx_snap[7], 0);
        chk("ovf_clr_ch7", rx_ovf[7], 0);
        chk("ovf_clr_glb", ovf_global, 0);

        // An RTC tick during readout is flagged and ignored.
        pulse_ch(1, 3);
        tick();
        readout(20);
        chk("rtcb_snap1", rx_snap[1], 3);
        chk("rtcb_flag", ovf_rtc_out, 1);
        b = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_out) b++;
            @(negedge clk);
        end
        chk("rtcb_no_resnap", b, 0);
        pulse_ch(1, 2);
        tick();
        readout(-10);
        chk("rtcb_next_snap1", rx_snap[1], 2);
        chk("rtcb_flag_clr", ovf_rtc_out, 0);

        // Reset in the middle of a shift aborts the readout and clears the live counters.
        tick();
        b = 0;
        while (!busy_out && b < 10) begin
            @(negedge clk);
            b++;
        end
        chk("mid_busy", busy_out, 1);
        cycles(5);
        pulse_ch(5, 2);
        cycles(16);
        chk("mid_addr", addr_out, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_addr", addr_out, 0);
        chk("mid_rst_sl", sl_out, 0);
        chk("mid_rst_serial", serial_out, 0);
        chk("mid_rst_ovf_ch", ovf_ch_out, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        chk("post_rst_busy", busy_out, 0);
        tick();
        readout(-10);
        chk("post_rst_cnt5", rx_snap[5], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "timeout");
    end
endmodule
